// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: single-cycle ALU path plus a FIFO-buffered load return path and a RAW scoreboard.
// Optional macro WB_FWD_EN adds same-cycle write-to-read forwarding ports.
module regfile_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_dest,
  input  logic [31:0]          alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_dest,
  input  logic [31:0]          ld_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_dest,
`ifdef WB_FWD_EN
  input  logic [4:0]           fwd_addr1,
  input  logic [4:0]           fwd_addr2,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic [31:0]          fwd_data1,
  output logic [31:0]          fwd_data2,
`endif
  output logic [31:0]          busy_mask,
  output logic [CNT_WIDTH-1:0] ld_count,
  output logic [4:0]           write,
  output logic [31:0]          write_data,
  output logic                 write_enable
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [4:0]       fifo_dest [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, ld_xfer, push, pop;

  logic             sel_vld_p0, sel_ld_p0;
  logic [4:0]       sel_dest_p0;
  logic [31:0]      sel_data_p0;
  logic [31:0]      busy_nxt;

  assign fifo_empty = (ld_count == '0);
  assign ld_ready   = (ld_count != FULL_CNT);
  assign ld_xfer    = ld_valid && ld_ready;

  // Stage p0: pick one result; ALU first, then the FIFO head, then a bypassing load.
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_ld_p0   = 1'b0;
    sel_dest_p0 = 5'd0;
    sel_data_p0 = 32'd0;
    push        = 1'b0;
    pop         = 1'b0;
    if (alu_valid) begin
      sel_vld_p0  = 1'b1;
      sel_dest_p0 = alu_dest;
      sel_data_p0 = alu_data;
      push        = ld_xfer;
    end else if (!fifo_empty) begin
      sel_vld_p0  = 1'b1;
      sel_ld_p0   = 1'b1;
      sel_dest_p0 = fifo_dest[rd_ptr];
      sel_data_p0 = fifo_data[rd_ptr];
      pop         = 1'b1;
      push        = ld_xfer;
    end else if (ld_xfer) begin
      sel_vld_p0  = 1'b1;
      sel_ld_p0   = 1'b1;
      sel_dest_p0 = ld_dest;
      sel_data_p0 = ld_data;
    end
  end

  // A same-cycle reservation overrides a clear; r0 can never be busy.
  always_comb begin
    busy_nxt = busy_mask;
    if (sel_ld_p0)
      busy_nxt[sel_dest_p0] = 1'b0;
    if (issue_valid)
      busy_nxt[issue_dest] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= ld_dest;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ld_count  <= '0;
      busy_mask <= 32'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   ld_count <= ld_count + CNT_WIDTH'(1);
        2'b01:   ld_count <= ld_count - CNT_WIDTH'(1);
        default: ld_count <= ld_count;
      endcase
      busy_mask <= busy_nxt;
    end
  end

  // Stage p1: registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write        <= 5'd0;
      write_data   <= 32'd0;
    end else begin
      write_enable <= sel_vld_p0 && (sel_dest_p0 != 5'd0);
      if (sel_vld_p0 && (sel_dest_p0 != 5'd0)) begin
        write      <= sel_dest_p0;
        write_data <= sel_data_p0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit1  = write_enable && (write == fwd_addr1) && (fwd_addr1 != 5'd0);
  assign fwd_hit2  = write_enable && (write == fwd_addr2) && (fwd_addr2 != 5'd0);
  assign fwd_data1 = write_data;
  assign fwd_data2 = write_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: stimulus queues expected writes, a negedge monitor checks them.
// Define WB_FWD_EN for both bench and design to exercise the forwarding ports.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_dest;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic [31:0] busy_mask;
  logic [2:0]  ld_count;
  logic [4:0]  write;
  logic [31:0] write_data;
  logic        write_enable;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  regfile_writeback #(.FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
`ifdef WB_FWD_EN
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .busy_mask(busy_mask), .ld_count(ld_count),
    .write(write), .write_data(write_data), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] d, input logic [31:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got dest %0d data 0x%08h, none expected", write, write_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_dest", {27'd0, write}, {27'd0, e.dest});
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int li;
    logic acc;
    rst = 1'b1;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
    issue_valid = 1'b0; issue_dest = '0;
`ifdef WB_FWD_EN
    fwd_addr1 = '0; fwd_addr2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_count", {29'd0, ld_count}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);

    // Back-to-back ALU results.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h11; exp_push(5'd5, 32'h11);
    @(posedge clk); #1;
    alu_dest = 5'd6; alu_data = 32'h22; exp_push(5'd6, 32'h22);
    @(posedge clk); #1;
    alu_valid = 1'b0;

    // Reservation then bypassed load return clears it.
    issue_valid = 1'b1; issue_dest = 5'd9;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("busy9_set", {31'd0, busy_mask[9]}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_dest = 5'd9; ld_data = 32'hDEAD; exp_push(5'd9, 32'hDEAD);
    @(negedge clk);
    chk("busy9_hold", {31'd0, busy_mask[9]}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("busy9_clr", {31'd0, busy_mask[9]}, 32'd0);

    // FIFO fill under a 6-cycle ALU burst; loads 1..5 drain afterwards in order.
    for (int i = 0; i < 6; i++) exp_push(5'(20 + i), 32'h100 + 32'(i));
    for (int i = 1; i <= 5; i++) exp_push(5'(i), 32'hA0 + 32'(i));
    @(posedge clk); #1;
    li = 1;
    for (int c = 0; c < 40 && li <= 5; c++) begin
      alu_valid = (c < 6);
      alu_dest  = 5'(20 + c);
      alu_data  = 32'h100 + 32'(c);
      ld_valid  = 1'b1;
      ld_dest   = 5'(li);
      ld_data   = 32'hA0 + 32'(li);
      if (c == 4) begin
        chk("full_ready", {31'd0, ld_ready}, 32'd0);
        chk("full_count", {29'd0, ld_count}, 32'd4);
      end
      if (c == 6) chk("pop_keeps_ready_low", {31'd0, ld_ready}, 32'd0);
      acc = ld_ready;
      @(posedge clk); #1;
      if (acc) li++;
    end
    chk("ld5_accepted", 32'(li), 32'd6);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("drain_count", {29'd0, ld_count}, 32'd0);

    // Register 0: no strobe, load consumed, no busy bit.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h55;
    issue_valid = 1'b1; issue_dest = 5'd0;
    @(posedge clk); #1;
    alu_valid = 1'b0; issue_valid = 1'b0;
    ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'h66;
    @(negedge clk);
    chk("r0_alu_we", {31'd0, write_enable}, 32'd0);
    chk("r0_busy", busy_mask, 32'd0);
    @(posedge clk); #1;
    chk("r0_ld_taken", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b0;
    @(negedge clk);
    chk("r0_ld_we", {31'd0, write_enable}, 32'd0);
    chk("r0_count", {29'd0, ld_count}, 32'd0);

    // Set and clear of register 7 in the same cycle: set wins.
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_dest = 5'd7;
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h77; exp_push(5'd7, 32'h77);
`ifdef WB_FWD_EN
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd3;
`endif
    @(posedge clk); #1;
    issue_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("busy7_setwins", {31'd0, busy_mask[7]}, 32'd1);
    chk("we7", {31'd0, write_enable}, 32'd1);
`ifdef WB_FWD_EN
    chk("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
    chk("fwd_data1", fwd_data1, 32'h77);
    chk("fwd_hit2", {31'd0, fwd_hit2}, 32'd0);
`endif

    // Reset with an entry in flight discards it and clears the scoreboard.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'hA10; exp_push(5'd10, 32'hA10);
    ld_valid = 1'b1; ld_dest = 5'd11; ld_data = 32'hB11;
    @(posedge clk); #1;
    alu_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", {29'd0, ld_count}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_count", {29'd0, ld_count}, 32'd0);
    chk("post_rst_busy", busy_mask, 32'd0);
    chk("post_rst_we", {31'd0, write_enable}, 32'd0);
    chk("post_rst_ready", {31'd0, ld_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
